// File: rtl/mem_arbiter_axi_pkg.sv
// Shared types and constants for the two-master AXI-lite BRAM arbiter.
// Holds the FSM encoding and the AXI response / error-data constants.
package mem_arbiter_axi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_axi_rr_arbiter2.sv
// Two-requester round-robin picker with its own last-grant register.
// Last grant resets to requester 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] pick
);

    logic last;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update && (|req)) begin
            last <= pick[1];
        end
    end

endmodule

// File: rtl/mem_arbiter_axi.sv
// Two-master AXI-lite arbiter in front of the shared program/data BRAM.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter_axi
    import mem_arbiter_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_axi_araddr,
    input  logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
    input  logic                  m0_axi_arvalid,
    input  logic                  m0_axi_awvalid,
    input  logic                  m0_axi_wvalid,
    input  logic [DATA_WIDTH-1:0] m0_axi_wdata,
    input  logic [3:0]            m0_axi_wstrb,
    input  logic                  m0_axi_rready,
    input  logic                  m0_b_ready,
    output logic                  m0_axi_arready,
    output logic                  m0_axi_awready,
    output logic                  m0_axi_wready,
    output logic [DATA_WIDTH-1:0] m0_axi_rdata,
    output logic                  m0_axi_rvalid,
    output logic                  m0_b_valid,
    output logic [1:0]            m0_b_response,
    input  logic [ADDR_WIDTH-1:0] m1_axi_araddr,
    input  logic [ADDR_WIDTH-1:0] m1_axi_awaddr,
    input  logic                  m1_axi_arvalid,
    input  logic                  m1_axi_awvalid,
    input  logic                  m1_axi_wvalid,
    input  logic [DATA_WIDTH-1:0] m1_axi_wdata,
    input  logic [3:0]            m1_axi_wstrb,
    input  logic                  m1_axi_rready,
    input  logic                  m1_b_ready,
    output logic                  m1_axi_arready,
    output logic                  m1_axi_awready,
    output logic                  m1_axi_wready,
    output logic [DATA_WIDTH-1:0] m1_axi_rdata,
    output logic                  m1_axi_rvalid,
    output logic                  m1_b_valid,
    output logic [1:0]            m1_b_response,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    output logic                  s_axi_arvalid,
    output logic                  s_axi_awvalid,
    output logic                  s_axi_wvalid,
    output logic [DATA_WIDTH-1:0] s_axi_wdata,
    output logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_rready,
    output logic                  s_b_ready,
    input  logic                  s_axi_arready,
    input  logic                  s_axi_awready,
    input  logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic                  s_axi_rvalid,
    input  logic                  s_b_valid,
    input  logic [1:0]            s_b_response,
    output logic [1:0]            grant
);

    state_t state, state_n;
    logic [1:0] grant_n, req, pick;
    logic       ar_done, aw_done, w_done;
    logic       ar_done_n, aw_done_n, w_done_n;
    logic       upd, fin, g, tmo;

    logic [1:0] arv, awv, wv, rr, br;
    logic [ADDR_WIDTH-1:0] ara [2];
    logic [ADDR_WIDTH-1:0] awa [2];
    logic [DATA_WIDTH-1:0] wd [2];
    logic [3:0]            ws [2];

    logic [1:0] ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;
    logic [DATA_WIDTH-1:0] r_dat [2];
    logic [1:0]            b_rsp [2];

    assign arv = {m1_axi_arvalid, m0_axi_arvalid};
    assign awv = {m1_axi_awvalid, m0_axi_awvalid};
    assign wv  = {m1_axi_wvalid, m0_axi_wvalid};
    assign rr  = {m1_axi_rready, m0_axi_rready};
    assign br  = {m1_b_ready, m0_b_ready};
    assign ara = '{m0_axi_araddr, m1_axi_araddr};
    assign awa = '{m0_axi_awaddr, m1_axi_awaddr};
    assign wd  = '{m0_axi_wdata, m1_axi_wdata};
    assign ws  = '{m0_axi_wstrb, m1_axi_wstrb};
    assign req = arv | awv;
    assign g   = grant[1];

    assign m0_axi_arready = ar_rdy[0];
    assign m0_axi_awready = aw_rdy[0];
    assign m0_axi_wready  = w_rdy[0];
    assign m0_axi_rvalid  = r_vld[0];
    assign m0_axi_rdata   = r_dat[0];
    assign m0_b_valid     = b_vld[0];
    assign m0_b_response  = b_rsp[0];
    assign m1_axi_arready = ar_rdy[1];
    assign m1_axi_awready = aw_rdy[1];
    assign m1_axi_wready  = w_rdy[1];
    assign m1_axi_rvalid  = r_vld[1];
    assign m1_axi_rdata   = r_dat[1];
    assign m1_b_valid     = b_vld[1];
    assign m1_b_response  = b_rsp[1];

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (upd),
        .pick   (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 2'b00;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            ar_done <= ar_done_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] cnt;

    // Counter restarts on every state change; tmo latches until exit.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state_n != state) begin
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            cnt <= cnt + 32'd1;
            if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                tmo <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign tmo = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        ar_done_n = ar_done;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        upd = 1'b0;
        fin = 1'b0;
        ar_rdy = '0;
        aw_rdy = '0;
        w_rdy  = '0;
        r_vld  = '0;
        b_vld  = '0;
        r_dat[0] = '0;
        r_dat[1] = '0;
        b_rsp[0] = RESP_OKAY;
        b_rsp[1] = RESP_OKAY;
        s_axi_araddr  = '0;
        s_axi_awaddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_rready  = 1'b0;
        s_b_ready     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    upd     = 1'b1;
                    grant_n = pick;
                    state_n = awv[pick[1]] ? WRITE : READ;
                end
            end
            READ: begin
                if (tmo) begin
                    r_vld[g] = 1'b1;
                    r_dat[g] = DATA_WIDTH'(ERR_RDATA);
                    fin      = rr[g];
                end else begin
                    s_axi_araddr  = ara[g];
                    s_axi_arvalid = arv[g] & ~ar_done;
                    ar_rdy[g]     = s_axi_arready & ~ar_done;
                    if (s_axi_arvalid && s_axi_arready) ar_done_n = 1'b1;
                    r_vld[g]     = s_axi_rvalid;
                    r_dat[g]     = s_axi_rdata;
                    s_axi_rready = rr[g];
                    fin          = s_axi_rvalid & rr[g];
                end
            end
            WRITE: begin
                if (tmo) begin
                    b_vld[g] = 1'b1;
                    b_rsp[g] = RESP_SLVERR;
                    fin      = br[g];
                end else begin
                    s_axi_awaddr  = awa[g];
                    s_axi_awvalid = awv[g] & ~aw_done;
                    aw_rdy[g]     = s_axi_awready & ~aw_done;
                    if (s_axi_awvalid && s_axi_awready) aw_done_n = 1'b1;
                    s_axi_wdata  = wd[g];
                    s_axi_wstrb  = ws[g];
                    s_axi_wvalid = wv[g] & ~w_done;
                    w_rdy[g]     = s_axi_wready & ~w_done;
                    if (s_axi_wvalid && s_axi_wready) w_done_n = 1'b1;
                    b_vld[g]  = s_b_valid;
                    b_rsp[g]  = s_b_response;
                    s_b_ready = br[g];
                    fin       = s_b_valid & br[g];
                end
            end
            default: state_n = IDLE;
        endcase
        if (fin) begin
            state_n   = IDLE;
            grant_n   = 2'b00;
            ar_done_n = 1'b0;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_axi.sv
// Directed bench for mem_arbiter_axi: single master, ties, alternation,
// slave stalls, reset mid-write and (with ARB_TIMEOUT_EN) the watchdog.
module tb_mem_arbiter_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_axi_araddr, m0_axi_awaddr, m0_axi_wdata;
    logic        m0_axi_arvalid, m0_axi_awvalid, m0_axi_wvalid;
    logic [3:0]  m0_axi_wstrb;
    logic        m0_axi_rready, m0_b_ready;
    logic        m0_axi_arready, m0_axi_awready, m0_axi_wready;
    logic [31:0] m0_axi_rdata;
    logic        m0_axi_rvalid, m0_b_valid;
    logic [1:0]  m0_b_response;
    logic [31:0] m1_axi_araddr, m1_axi_awaddr, m1_axi_wdata;
    logic        m1_axi_arvalid, m1_axi_awvalid, m1_axi_wvalid;
    logic [3:0]  m1_axi_wstrb;
    logic        m1_axi_rready, m1_b_ready;
    logic        m1_axi_arready, m1_axi_awready, m1_axi_wready;
    logic [31:0] m1_axi_rdata;
    logic        m1_axi_rvalid, m1_b_valid;
    logic [1:0]  m1_b_response;
    logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata;
    logic        s_axi_arvalid, s_axi_awvalid, s_axi_wvalid;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_rready, s_b_ready;
    logic        s_axi_arready, s_axi_awready, s_axi_wready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rvalid, s_b_valid;
    logic [1:0]  s_b_response;
    logic [1:0]  grant;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter_axi #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .m0_axi_araddr(m0_axi_araddr), .m0_axi_awaddr(m0_axi_awaddr),
        .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_awvalid(m0_axi_awvalid),
        .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wdata(m0_axi_wdata),
        .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_rready(m0_axi_rready),
        .m0_b_ready(m0_b_ready), .m0_axi_arready(m0_axi_arready),
        .m0_axi_awready(m0_axi_awready), .m0_axi_wready(m0_axi_wready),
        .m0_axi_rdata(m0_axi_rdata), .m0_axi_rvalid(m0_axi_rvalid),
        .m0_b_valid(m0_b_valid), .m0_b_response(m0_b_response),
        .m1_axi_araddr(m1_axi_araddr), .m1_axi_awaddr(m1_axi_awaddr),
        .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_awvalid(m1_axi_awvalid),
        .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wdata(m1_axi_wdata),
        .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_rready(m1_axi_rready),
        .m1_b_ready(m1_b_ready), .m1_axi_arready(m1_axi_arready),
        .m1_axi_awready(m1_axi_awready), .m1_axi_wready(m1_axi_wready),
        .m1_axi_rdata(m1_axi_rdata), .m1_axi_rvalid(m1_axi_rvalid),
        .m1_b_valid(m1_b_valid), .m1_b_response(m1_b_response),
        .s_axi_araddr(s_axi_araddr), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_rready(s_axi_rready),
        .s_b_ready(s_b_ready), .s_axi_arready(s_axi_arready),
        .s_axi_awready(s_axi_awready), .s_axi_wready(s_axi_wready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid),
        .s_b_valid(s_b_valid), .s_b_response(s_b_response),
        .grant(grant)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {m0_axi_araddr, m0_axi_awaddr, m0_axi_wdata, m0_axi_wstrb} = '0;
        {m0_axi_arvalid, m0_axi_awvalid, m0_axi_wvalid} = '0;
        {m0_axi_rready, m0_b_ready} = '0;
        {m1_axi_araddr, m1_axi_awaddr, m1_axi_wdata, m1_axi_wstrb} = '0;
        {m1_axi_arvalid, m1_axi_awvalid, m1_axi_wvalid} = '0;
        {m1_axi_rready, m1_b_ready} = '0;
        {s_axi_arready, s_axi_awready, s_axi_wready} = '0;
        {s_axi_rdata, s_axi_rvalid, s_b_valid, s_b_response} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        int n1;
        logic [1:0] exp_g;
        clear_inputs();
        do_reset();
        #1;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_s_valids", 32'({s_axi_arvalid, s_axi_awvalid, s_axi_wvalid}), 32'h0);
        chk("reset_m0_readies", 32'({m0_axi_arready, m0_axi_awready, m0_axi_wready}), 32'h0);
        chk("reset_m0_rdata", m0_axi_rdata, 32'h0);

        // master 0 write 0x10 <- 0x12345678
        m0_axi_awaddr = 32'h10; m0_axi_awvalid = 1'b1;
        m0_axi_wdata = 32'h1234_5678; m0_axi_wstrb = 4'hF; m0_axi_wvalid = 1'b1;
        s_axi_awready = 1'b1; s_axi_wready = 1'b1;
        #1;
        chk("idle_no_awready", 32'(m0_axi_awready), 32'h0);
        chk("idle_no_s_awvalid", 32'(s_axi_awvalid), 32'h0);
        step();
        chk("wr_grant", 32'(grant), 32'h1);
        chk("wr_s_awaddr", s_axi_awaddr, 32'h10);
        chk("wr_s_wdata", s_axi_wdata, 32'h1234_5678);
        chk("wr_s_wstrb", 32'(s_axi_wstrb), 32'hF);
        chk("wr_m0_readies", 32'({m0_axi_awready, m0_axi_wready}), 32'h3);
        step();
        m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0;
        s_b_valid = 1'b1; s_b_response = 2'b00; m0_b_ready = 1'b1;
        #1;
        chk("wr_aw_done", 32'(s_axi_awvalid), 32'h0);
        chk("wr_b_valid", 32'(m0_b_valid), 32'h1);
        chk("wr_b_resp", 32'(m0_b_response), 32'h0);
        step();
        s_b_valid = 1'b0; m0_b_ready = 1'b0;
        chk("wr_done_idle", 32'(grant), 32'h0);

        // master 0 read back
        m0_axi_araddr = 32'h10; m0_axi_arvalid = 1'b1; s_axi_arready = 1'b1;
        step();
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_s_araddr", s_axi_araddr, 32'h10);
        chk("rd_m0_arready", 32'(m0_axi_arready), 32'h1);
        step();
        m0_axi_arvalid = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rdata = 32'h1234_5678; m0_axi_rready = 1'b1;
        #1;
        chk("rd_ar_done", 32'(s_axi_arvalid), 32'h0);
        chk("rd_m0_rdata", m0_axi_rdata, 32'h1234_5678);
        chk("rd_m0_rvalid", 32'(m0_axi_rvalid), 32'h1);
        step();
        clear_inputs();

        // simultaneous reads after reset: 01, 00, 10
        do_reset();
        m0_axi_araddr = 32'h100; m0_axi_arvalid = 1'b1;
        m1_axi_araddr = 32'h200; m1_axi_arvalid = 1'b1;
        s_axi_arready = 1'b1;
        step();
        chk("tie_first", 32'(grant), 32'h1);
        chk("tie_m1_stalled", 32'(m1_axi_arready), 32'h0);
        step();
        m0_axi_arvalid = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rdata = 32'hAAAA_0000;
        m0_axi_rready = 1'b1; m1_axi_rready = 1'b1;
        #1;
        chk("tie_m0_rdata", m0_axi_rdata, 32'hAAAA_0000);
        chk("tie_m1_rvalid", 32'(m1_axi_rvalid), 32'h0);
        chk("tie_m1_rdata", m1_axi_rdata, 32'h0);
        step();
        s_axi_rvalid = 1'b0;
        chk("tie_gap", 32'(grant), 32'h0);
        step();
        chk("tie_second", 32'(grant), 32'h2);
        chk("tie_s_araddr", s_axi_araddr, 32'h200);
        step();
        m1_axi_arvalid = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rdata = 32'hBBBB_0000;
        #1;
        chk("tie_m1_rdata2", m1_axi_rdata, 32'hBBBB_0000);
        step();
        clear_inputs();

        // both masters keep requesting: strict alternation starting at 0
        m0_axi_arvalid = 1'b1; m1_axi_arvalid = 1'b1;
        m0_axi_rready = 1'b1; m1_axi_rready = 1'b1;
        s_axi_arready = 1'b1; s_axi_rvalid = 1'b1;
        exp_g = 2'b01;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4 && grant == 2'b00; k++) step();
            chk($sformatf("alt_%0d", i), 32'(grant), 32'(exp_g));
            chk($sformatf("alt_overlap_%0d", i),
                32'(m0_axi_rvalid & m1_axi_rvalid), 32'h0);
            if (grant == 2'b01) n0++;
            if (grant == 2'b10) n1++;
            exp_g = ~exp_g;
            step();
        end
        chk("alt_m0_count", 32'(n0), 32'd4);
        chk("alt_m1_count", 32'(n1), 32'd4);
        clear_inputs();

        // W lags AW by 3 cycles; master 1 waits
        do_reset();
        m0_axi_awaddr = 32'h40; m0_axi_awvalid = 1'b1;
        m0_axi_wdata = 32'hCAFE_F00D; m0_axi_wstrb = 4'h3; m0_axi_wvalid = 1'b1;
        m1_axi_araddr = 32'h80; m1_axi_arvalid = 1'b1;
        s_axi_awready = 1'b1;
        step();
        chk("stall_grant", 32'(grant), 32'h1);
        chk("stall_wvalid", 32'({s_axi_awvalid, s_axi_wvalid}), 32'h3);
        chk("stall_m0_wready", 32'(m0_axi_wready), 32'h0);
        step();
        m0_axi_awvalid = 1'b0;
        #1;
        chk("stall_aw_done", 32'({s_axi_awvalid, s_axi_wvalid}), 32'h1);
        step();
        step();
        s_axi_wready = 1'b1;
        #1;
        chk("stall_m0_wready_late", 32'(m0_axi_wready), 32'h1);
        chk("stall_keep_grant", 32'(grant), 32'h1);
        chk("stall_m1_blocked", 32'({m1_axi_arready, s_axi_arvalid}), 32'h0);
        step();
        m0_axi_wvalid = 1'b0; s_axi_wready = 1'b0;
        s_b_valid = 1'b1; m0_b_ready = 1'b1;
        #1;
        chk("stall_b_valid", 32'(m0_b_valid), 32'h1);
        step();
        chk("stall_b_once", 32'(m0_b_valid), 32'h0);
        chk("stall_idle", 32'(grant), 32'h0);
        s_b_valid = 1'b0;
        s_axi_arready = 1'b1; s_axi_rvalid = 1'b1; m1_axi_rready = 1'b1;
        step();
        chk("stall_m1_grant", 32'(grant), 32'h2);
        step();
        clear_inputs();

        // reset in the middle of a write
        m0_axi_awaddr = 32'h44; m0_axi_awvalid = 1'b1;
        step();
        step();
        chk("rstmid_grant", 32'(grant), 32'h1);
        chk("rstmid_s_awvalid", 32'(s_axi_awvalid), 32'h1);
        rst = 1'b1;
        step();
        chk("rstmid_grant0", 32'(grant), 32'h0);
        chk("rstmid_valids",
            32'({s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, m0_axi_awready}), 32'h0);
        rst = 1'b0;
        m0_axi_awvalid = 1'b0;
        step();
        chk("rstmid_stay_idle", 32'(grant), 32'h0);
        clear_inputs();

`ifdef ARB_TIMEOUT_EN
        do_reset();
        m0_axi_araddr = 32'h8; m0_axi_arvalid = 1'b1;
        s_axi_arready = 1'b1;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("to_before", 32'(m0_axi_rvalid), 32'h0);
        step();
        chk("to_rvalid", 32'(m0_axi_rvalid), 32'h1);
        chk("to_rdata", m0_axi_rdata, 32'hDEAD_BEEF);
        chk("to_s_arvalid", 32'(s_axi_arvalid), 32'h0);
        m0_axi_arvalid = 1'b0;
        m0_axi_rready = 1'b1;
        step();
        chk("to_idle", 32'(grant), 32'h0);
        clear_inputs();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
